// File: rtl/bluejay_data_rx.sv
// Bluejay SLM link receiver: undoes optional inversion, tracks line/frame framing and
// hands words to a downstream consumer through a 2-entry ready/valid buffer.
module bluejay_data_rx #(
  parameter int unsigned WORDS_PER_LINE  = 40,
  parameter int unsigned LINES_PER_FRAME = 1024
) (
  input  logic        fpga_clk,
  input  logic        reset_all,
  input  logic [31:0] data_i,
  input  logic        sync_i,
  input  logic        valid_i,
  input  logic        update_i,
  input  logic        invert_i,
  output logic [31:0] rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        line_done_o,
  output logic        frame_done_o,
  output logic [10:0] line_count_o,
  output logic        err_len_o,
  output logic        err_sync_o,
  output logic        err_ovf_o,
  input  logic        clear_err_i
);

  localparam int unsigned WcW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam logic [WcW-1:0] WcLast = WcW'(WORDS_PER_LINE - 1);
  localparam logic [10:0] LinesExp = 11'(LINES_PER_FRAME);

  typedef enum logic [0:0] {StIdle, StLine} state_e;

  state_e         state_q, state_d;
  logic [WcW-1:0] word_cnt_q, word_cnt_d, word_idx;
  logic [10:0]    line_cnt_q, line_cnt_d;
  logic           line_done_q, line_done_d;
  logic           frame_done_q, frame_done_d;
  logic           err_len_q, err_sync_q, err_ovf_q;
  logic           set_len, set_sync, set_ovf;
  logic           push, take_word;

  logic [31:0]    mem_q [2];
  logic           rd_ptr_q, wr_ptr_q;
  logic [1:0]     cnt_q, cnt_d;
  logic           pop, push_ok;
  logic [31:0]    word_in;

  // Link-side framing; update_i outranks sync_i, which outranks valid_i.
  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    line_cnt_d   = line_cnt_q;
    line_done_d  = 1'b0;
    frame_done_d = 1'b0;
    set_len      = 1'b0;
    set_sync     = 1'b0;
    take_word    = 1'b0;
    push         = 1'b0;
    word_idx     = word_cnt_q;
    if (update_i) begin
      frame_done_d = 1'b1;
      line_cnt_d   = '0;
      word_cnt_d   = '0;
      state_d      = StIdle;
      if (state_q == StLine || line_cnt_q != LinesExp) set_len = 1'b1;
    end else begin
      if (sync_i) begin
        if (state_q == StLine && word_cnt_q != '0) set_sync = 1'b1;
        state_d    = StLine;
        word_cnt_d = '0;
        word_idx   = '0;
        take_word  = valid_i;
      end else if (valid_i) begin
        if (state_q == StLine) take_word = 1'b1;
        else                   set_sync  = 1'b1;
      end
      if (take_word) begin
        push = 1'b1;
        if (word_idx == WcLast) begin
          line_done_d = 1'b1;
          if (line_cnt_q != 11'h7ff) line_cnt_d = line_cnt_q + 11'd1;
          word_cnt_d  = '0;
          state_d     = StIdle;
        end else begin
          word_cnt_d = word_idx + WcW'(1);
        end
      end
    end
  end

  assign word_in    = invert_i ? ~data_i : data_i;
  assign rx_valid_o = (cnt_q != 2'd0);
  assign pop        = rx_valid_o & rx_ready_i;
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign push_ok    = push & ((cnt_q != 2'd2) | pop);
  assign set_ovf    = push & (cnt_q == 2'd2) & ~pop;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge fpga_clk or negedge reset_all) begin
    if (!reset_all) begin
      state_q      <= StIdle;
      word_cnt_q   <= '0;
      line_cnt_q   <= '0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_len_q    <= 1'b0;
      err_sync_q   <= 1'b0;
      err_ovf_q    <= 1'b0;
      mem_q[0]     <= '0;
      mem_q[1]     <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      cnt_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      line_cnt_q   <= line_cnt_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
      // Setting an error wins over a coincident clear.
      err_len_q    <= set_len  | (err_len_q  & ~clear_err_i);
      err_sync_q   <= set_sync | (err_sync_q & ~clear_err_i);
      err_ovf_q    <= set_ovf  | (err_ovf_q  & ~clear_err_i);
      if (push_ok) begin
        mem_q[wr_ptr_q] <= word_in;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

  assign rx_data_o    = mem_q[rd_ptr_q];
  assign line_done_o  = line_done_q;
  assign frame_done_o = frame_done_q;
  assign line_count_o = line_cnt_q;
  assign err_len_o    = err_len_q;
  assign err_sync_o   = err_sync_q;
  assign err_ovf_o    = err_ovf_q;

endmodule

// File: tb/tb_bluejay_data_rx.sv
// Self-checking bench for bluejay_data_rx with 4 words/line and 2 lines/frame; delivered
// words are checked against a scoreboard queue filled as stimulus is driven.
module tb_bluejay_data_rx;

  logic        fpga_clk = 1'b0;
  logic        reset_all;
  logic [31:0] data_i;
  logic        sync_i, valid_i, update_i, invert_i, rx_ready_i, clear_err_i;
  logic [31:0] rx_data_o;
  logic        rx_valid_o, line_done_o, frame_done_o;
  logic [10:0] line_count_o;
  logic        err_len_o, err_sync_o, err_ovf_o;

  int          checks = 0;
  int          fails  = 0;
  int          ld_cnt = 0;
  logic [31:0] exp_q[$];

  bluejay_data_rx #(
    .WORDS_PER_LINE (4),
    .LINES_PER_FRAME(2)
  ) dut (
    .fpga_clk    (fpga_clk),
    .reset_all   (reset_all),
    .data_i      (data_i),
    .sync_i      (sync_i),
    .valid_i     (valid_i),
    .update_i    (update_i),
    .invert_i    (invert_i),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .line_done_o (line_done_o),
    .frame_done_o(frame_done_o),
    .line_count_o(line_count_o),
    .err_len_o   (err_len_o),
    .err_sync_o  (err_sync_o),
    .err_ovf_o   (err_ovf_o),
    .clear_err_i (clear_err_i)
  );

  always #5 fpga_clk = ~fpga_clk;

  // Scoreboard: a word leaving the buffer at the next rising edge must match the queue head.
  always @(negedge fpga_clk) begin
    if (reset_all && rx_valid_o && rx_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_extra: got word %h, expected no word", rx_data_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rx_data_o !== e) begin
          fails++;
          $display("FAIL scoreboard_word: got %h, expected %h", rx_data_o, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge fpga_clk);
    #1;
  endtask

  task automatic idle_inputs();
    data_i = '0; sync_i = 0; valid_i = 0; update_i = 0; invert_i = 0; clear_err_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rx_ready_i = 1;
    reset_all  = 0;
    exp_q.delete();
    step();
    step();
    reset_all = 1;
    ld_cnt    = 0;
  endtask

  task automatic drive_word(input logic [31:0] d, input logic inv, input logic expect_out);
    data_i   = d;
    invert_i = inv;
    valid_i  = 1;
    if (expect_out) exp_q.push_back(inv ? ~d : d);
    step();
    valid_i  = 0;
    invert_i = 0;
    if (line_done_o) ld_cnt++;
  endtask

  task automatic pulse_sync();
    sync_i = 1;
    step();
    sync_i = 0;
  endtask

  task automatic pulse_update();
    update_i = 1;
    step();
    update_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rx_ready_i = 1;
    reset_all  = 0;
    #3;
    checks++;
    if ({rx_data_o, rx_valid_o, line_done_o, frame_done_o, line_count_o,
         err_len_o, err_sync_o, err_ovf_o} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got data=%h valid=%b lc=%0d errs=%b%b%b, expected all 0",
               rx_data_o, rx_valid_o, line_count_o, err_len_o, err_sync_o, err_ovf_o);
    end
    do_reset();
  endtask

  task automatic test_basic_frame();
    logic [31:0] w;
    do_reset();
    for (int ln = 0; ln < 2; ln++) begin
      pulse_sync();
      for (int i = 0; i < 4; i++) begin
        w = 32'h11111111 * (i + 1) + 32'h01010101 * ln;
        drive_word(w, 1'b0, 1'b1);
        checks++;
        if (rx_valid_o !== 1'b1 || rx_data_o !== w) begin
          fails++;
          $display("FAIL basic_latency: got valid=%b data=%h, expected valid=1 data=%h",
                   rx_valid_o, rx_data_o, w);
        end
      end
      checks++;
      if (line_done_o !== 1'b1 || line_count_o !== 11'(ln + 1)) begin
        fails++;
        $display("FAIL basic_line_done: got ld=%b lc=%0d, expected ld=1 lc=%0d",
                 line_done_o, line_count_o, ln + 1);
      end
    end
    pulse_update();
    checks++;
    if (frame_done_o !== 1'b1 || line_count_o !== 11'd0) begin
      fails++;
      $display("FAIL basic_frame_done: got fd=%b lc=%0d, expected fd=1 lc=0",
               frame_done_o, line_count_o);
    end
    step();
    checks++;
    if ({err_len_o, err_sync_o, err_ovf_o} !== 3'b000 || ld_cnt != 2 || exp_q.size() != 0
        || frame_done_o !== 1'b0) begin
      fails++;
      $display("FAIL basic_tail: got errs=%b%b%b ld_cnt=%0d left=%0d fd=%b, expected 000 2 0 0",
               err_len_o, err_sync_o, err_ovf_o, ld_cnt, exp_q.size(), frame_done_o);
    end
  endtask

  task automatic test_invert();
    do_reset();
    pulse_sync();
    drive_word(32'h0000ffff, 1'b1, 1'b1);
    checks++;
    if (rx_data_o !== 32'hffff0000) begin
      fails++;
      $display("FAIL invert_word: got %h, expected ffff0000", rx_data_o);
    end
    drive_word(32'h12345678, 1'b0, 1'b1);
    checks++;
    if (rx_data_o !== 32'h12345678) begin
      fails++;
      $display("FAIL invert_toggle_off: got %h, expected 12345678", rx_data_o);
    end
    drive_word(32'h12345678, 1'b1, 1'b1);
    checks++;
    if (rx_data_o !== 32'hedcba987) begin
      fails++;
      $display("FAIL invert_toggle_on: got %h, expected edcba987", rx_data_o);
    end
    drive_word(32'hcafef00d, 1'b0, 1'b1);
    step();
    checks++;
    if (exp_q.size() != 0 || line_count_o !== 11'd1) begin
      fails++;
      $display("FAIL invert_drain: got left=%0d lc=%0d, expected 0 1", exp_q.size(), line_count_o);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    rx_ready_i = 0;
    pulse_sync();
    drive_word(32'haaaa0001, 1'b0, 1'b1);
    drive_word(32'haaaa0002, 1'b0, 1'b1);
    checks++;
    if (rx_data_o !== 32'haaaa0001 || rx_valid_o !== 1'b1 || err_ovf_o !== 1'b0) begin
      fails++;
      $display("FAIL ovf_hold: got data=%h valid=%b ovf=%b, expected aaaa0001 1 0",
               rx_data_o, rx_valid_o, err_ovf_o);
    end
    drive_word(32'haaaa0003, 1'b0, 1'b0);
    checks++;
    if (rx_data_o !== 32'haaaa0001 || err_ovf_o !== 1'b1) begin
      fails++;
      $display("FAIL ovf_flag: got data=%h ovf=%b, expected aaaa0001 1", rx_data_o, err_ovf_o);
    end
    drive_word(32'haaaa0004, 1'b0, 1'b0);
    checks++;
    if (line_done_o !== 1'b1 || line_count_o !== 11'd1) begin
      fails++;
      $display("FAIL ovf_line_done: got ld=%b lc=%0d, expected 1 1", line_done_o, line_count_o);
    end
    rx_ready_i = 1;
    step();
    step();
    checks++;
    if (rx_valid_o !== 1'b0 || exp_q.size() != 0 || err_ovf_o !== 1'b1) begin
      fails++;
      $display("FAIL ovf_drain: got valid=%b left=%0d ovf=%b, expected 0 0 1",
               rx_valid_o, exp_q.size(), err_ovf_o);
    end
  endtask

  task automatic test_resync();
    do_reset();
    pulse_sync();
    drive_word(32'h0000000a, 1'b0, 1'b1);
    drive_word(32'h0000000b, 1'b0, 1'b1);
    pulse_sync();
    checks++;
    if (err_sync_o !== 1'b1 || line_count_o !== 11'd0) begin
      fails++;
      $display("FAIL resync_err: got sync_err=%b lc=%0d, expected 1 0", err_sync_o, line_count_o);
    end
    for (int i = 0; i < 4; i++) drive_word(32'hb0000000 + i, 1'b0, 1'b1);
    step();
    step();
    checks++;
    if (ld_cnt != 1 || line_count_o !== 11'd1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL resync_count: got ld_cnt=%0d lc=%0d left=%0d, expected 1 1 0",
               ld_cnt, line_count_o, exp_q.size());
    end
  endtask

  task automatic test_idle_valid();
    do_reset();
    drive_word(32'hdeadbeef, 1'b0, 1'b0);
    checks++;
    if (err_sync_o !== 1'b1 || rx_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL idle_valid: got sync_err=%b valid=%b, expected 1 0", err_sync_o, rx_valid_o);
    end
    clear_err_i = 1;
    step();
    checks++;
    if (err_sync_o !== 1'b0) begin
      fails++;
      $display("FAIL idle_clear: got sync_err=%b, expected 0", err_sync_o);
    end
    drive_word(32'hdeadbeef, 1'b0, 1'b0);
    clear_err_i = 0;
    checks++;
    if (err_sync_o !== 1'b1) begin
      fails++;
      $display("FAIL idle_set_wins: got sync_err=%b, expected 1", err_sync_o);
    end
  endtask

  task automatic test_short_frame();
    do_reset();
    pulse_sync();
    for (int i = 0; i < 4; i++) drive_word(32'hc0000000 + i, 1'b0, 1'b1);
    pulse_update();
    checks++;
    if (err_len_o !== 1'b1 || frame_done_o !== 1'b1 || line_count_o !== 11'd0) begin
      fails++;
      $display("FAIL short_frame: got len_err=%b fd=%b lc=%0d, expected 1 1 0",
               err_len_o, frame_done_o, line_count_o);
    end
  endtask

  task automatic test_update_mid_line();
    do_reset();
    pulse_sync();
    drive_word(32'hd0000001, 1'b0, 1'b1);
    drive_word(32'hd0000002, 1'b0, 1'b1);
    pulse_update();
    checks++;
    if (err_len_o !== 1'b1 || frame_done_o !== 1'b1 || line_count_o !== 11'd0) begin
      fails++;
      $display("FAIL update_mid: got len_err=%b fd=%b lc=%0d, expected 1 1 0",
               err_len_o, frame_done_o, line_count_o);
    end
    // Back in IDLE, so a lone word must be rejected as a protocol error.
    drive_word(32'hd0000003, 1'b0, 1'b0);
    step();
    checks++;
    if (err_sync_o !== 1'b1 || exp_q.size() != 0 || rx_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL update_mid_idle: got sync_err=%b left=%0d valid=%b, expected 1 0 0",
               err_sync_o, exp_q.size(), rx_valid_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    rx_ready_i = 0;
    pulse_sync();
    drive_word(32'he0000001, 1'b0, 1'b0);
    drive_word(32'he0000002, 1'b0, 1'b0);
    drive_word(32'he0000003, 1'b0, 1'b0);
    #2;
    reset_all = 0;
    #1;
    checks++;
    if ({rx_data_o, rx_valid_o, line_done_o, frame_done_o, line_count_o,
         err_len_o, err_sync_o, err_ovf_o} !== '0) begin
      fails++;
      $display("FAIL async_reset: got data=%h valid=%b lc=%0d ovf=%b, expected all 0",
               rx_data_o, rx_valid_o, line_count_o, err_ovf_o);
    end
    do_reset();
  endtask

  initial begin
    reset_all  = 0;
    rx_ready_i = 1;
    idle_inputs();
    test_reset();
    test_basic_frame();
    test_invert();
    test_overflow();
    test_resync();
    test_idle_valid();
    test_short_frame();
    test_update_mid_line();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/bluejay_data_rx.md
Name: bluejay_data_rx

Overview:
- Receive-side counterpart of the Bluejay SLM data transmitter.
- Consumes the 32-bit data/sync/valid/update stream, undoes optional inversion, and counts words per line and lines per frame.
- Hands words to a downstream consumer through a 2-entry ready/valid buffer.
- Used for loopback capture and frame-integrity checking, and as a link monitor in system sim and on hardware.

Parameters:
WORDS_PER_LINE, 40, 32-bit words per display line (1280 px / 32).
LINES_PER_FRAME, 1024, lines expected between update pulses.

Ports:
fpga_clk  input  1  system clock; all logic on rising edge
reset_all  input  1  asynchronous, active-low reset
data_i  input  32  link data word
sync_i  input  1  one-cycle start-of-line strobe
valid_i  input  1  data_i carries a line word this cycle
update_i  input  1  one-cycle end-of-frame strobe
invert_i  input  1  when 1, stored word = ~data_i (sampled per word)
rx_data_o  output  32  captured word (head of buffer)
rx_valid_o  output  1  rx_data_o valid
rx_ready_i  input  1  consumer accepts when rx_valid_o & rx_ready_i
line_done_o  output  1  one-cycle pulse, full line received
frame_done_o  output  1  one-cycle pulse, update_i seen
line_count_o  output  11  lines completed in current frame
err_len_o  output  1  sticky: bad frame/line length
err_sync_o  output  1  sticky: protocol violation
err_ovf_o  output  1  sticky: buffer overflow, word dropped
clear_err_i  input  1  clears sticky errors

Behaviour:
- Reset (reset_all=0, async): FSM=IDLE, word_cnt=0, line_count_o=0, buffer empty.
- All outputs are 0 during reset, including rx_data_o=0.
- Counters:
  - word_cnt width = clog2(WORDS_PER_LINE).
  - line_count_o is 11 bits and saturates at 2047.
- FSM states IDLE and LINE. Precedence within a cycle: update_i > sync_i > valid_i.
- IDLE:
  - sync_i -> LINE, word_cnt=0.
  - valid_i without sync_i -> word dropped, err_sync_o=1.
  - update_i -> frame_done_o pulse next cycle.
    - err_len_o=1 if line_count_o != LINES_PER_FRAME.
    - line_count_o cleared to 0.
- LINE:
  - valid_i -> word pushed to buffer, word_cnt+1.
    - On the word where word_cnt==WORDS_PER_LINE-1: line_done_o pulses next cycle, line_count_o+1, FSM -> IDLE.
  - Gaps (valid_i=0) are allowed with no limit.
  - sync_i while LINE (word_cnt>0) -> err_sync_o=1, partial line discarded from counting (words already buffered are kept), word_cnt=0, stay LINE.
  - sync_i with valid_i in the same cycle: the sync is applied and the word counts as word 0.
  - update_i while LINE -> err_len_o=1, frame_done_o pulse, line_count_o=0, FSM -> IDLE. A coincident valid word is dropped.
- Buffer (2 entries, FIFO order):
  - Push and pop in the same cycle are legal; occupancy is unchanged.
  - Latency: word on cycle N reaches rx_data_o/rx_valid_o at N+1 when the buffer is empty.
  - rx_data_o is stable while rx_valid_o=1 and rx_ready_i=0.
  - Push when full with no pop -> word dropped, err_ovf_o=1, word_cnt still advances (line accounting is link-side).
- Sticky errors:
  - Set has priority over clear_err_i in the same cycle.
  - clear_err_i does not affect counters or the buffer.
- Reset mid-line or mid-frame: immediate return to the reset state; buffered words are lost.

Test Plan:
- Params 4/2, rx_ready_i=1, invert_i=0:
  - Stimulus: sync, words 0x11111111..0x44444444, sync, 4 words, update.
  - Response: 8 words in order, each 1 cycle after input; line_done_o pulses twice; line_count_o 1 then 2; frame_done_o pulse; no errors; line_count_o returns to 0.
- invert_i=1, word 0x0000FFFF -> rx_data_o=0xFFFF0000.
- Toggling invert_i per word applies per word.
- Params 4/2, rx_ready_i=0, one line of 4 words:
  - Words 1–2 are held, with rx_data_o=word1 stable.
  - Words 3–4 are dropped and err_ovf_o=1; line_done_o still pulses.
  - Raising rx_ready_i drains word1 then word2.
- Params 4/2, sync, 2 words, sync, 4 words:
  - err_sync_o=1; one line_done_o; line_count_o=1; 6 words delivered.
- Params 4/2, valid_i in IDLE:
  - Word dropped, err_sync_o=1.
  - clear_err_i=1 clears it; a coincident new violation keeps it set.
- Params 4/2, one full line then update:
  - err_len_o=1 (count 1≠2), frame_done_o pulses.
- Params 4/2, update mid-line after 2 words:
  - err_len_o=1, FSM IDLE, line_count_o=0.
- reset_all low mid-line:
  - All outputs are 0 asynchronously.
